// File: rtl/ball_hit_detector.sv
// ball_hit_detector
// ---------------------------------------------------------------------------
// Per-frame collision sampler. It watches the object code at four probe pixels
// just outside the ball bounding box (Left, Top, Right, Bottom). It accumulates
// code-set matches over one frame and publishes a registered hit vector at each
// startOfFrame.
//
// Optional feature macro: HIT_CORNER_PROBES_EN adds four diagonal corner probes.
//
// Ports:
//   clk          pixel clock
//   resetN       asynchronous active-low reset
//   startOfFrame one-cycle pulse at pixel (0,0)
//   pixelX/Y     current raster position (11 bit)
//   ballX/Y      ball top-left position (11 bit), latched at startOfFrame
//   objCode      topmost non-ball object code at the raster position, 0 = none
//   hit          {L,T,R,B} hits of the last completed frame
//   hitObj       code of the highest-priority hit side (L>T>R>B), 0 if none
//   hitValid     one-cycle strobe when hit/hitObj update
// ---------------------------------------------------------------------------
module ball_hit_detector #(
    parameter int unsigned      BALL_SIZE       = 16,
    parameter logic [3:0][15:0] HIT_CODES       = {16'hC446, 16'h8C62, 16'h8932, 16'h9113},
    parameter int unsigned      COOLDOWN_FRAMES = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [10:0] ballX,
    input  logic [10:0] ballY,
    input  logic [3:0]  objCode,
    output logic [3:0]  hit,
    output logic [3:0]  hitObj,
    output logic        hitValid
);

    // Side index equals the bit position in hit and the slot in HIT_CODES.
    localparam int S_L = 3;
    localparam int S_T = 2;
    localparam int S_R = 1;
    localparam int S_B = 0;

    localparam logic [11:0] HALF    = 12'(BALL_SIZE / 2);
    localparam logic [11:0] SIZE    = 12'(BALL_SIZE);
    localparam logic [7:0]  CD_LOAD = 8'(COOLDOWN_FRAMES);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [10:0]      bx_r, bx_s, by_r, by_s;
    logic [3:0]       acc_r, acc_s, acc_base_s;
    logic [3:0][3:0]  acc_code_r, acc_code_s, code_base_s;
    logic [7:0]       cd_cnt_r, cd_cnt_s;
    logic [3:0]       hit_r, hit_s, hit_obj_r, hit_obj_s, prio_obj_s;
    logic             hit_valid_r, hit_valid_s;
    logic [11:0]      ex_s, ey_s;
    logic [3:0]       match_s;

    // True when code is non-zero and equals one of the four nibbles of codes.
    function automatic logic code_in_set(input logic [3:0] code, input logic [15:0] codes);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            found = found | (codes[i*4 +: 4] == code);
        end
        return found & (code != 4'd0);
    endfunction

    // A probe with a negative coordinate (bit 11 set) can never be reached.
    function automatic logic at_probe(input logic [11:0] px, input logic [11:0] py,
                                      input logic [10:0] x,  input logic [10:0] y);
        return !px[11] && !py[11] && (px[10:0] == x) && (py[10:0] == y);
    endfunction

    // Probe matching. On the startOfFrame cycle the pixel belongs to the new
    // frame, so the incoming ball position is used instead of the latched one.
    always_comb begin
        ex_s = {1'b0, (startOfFrame ? ballX : bx_r)};
        ey_s = {1'b0, (startOfFrame ? ballY : by_r)};
        match_s = 4'd0;
        match_s[S_L] = at_probe(ex_s - 12'd1, ey_s + HALF, pixelX, pixelY)
                       && code_in_set(objCode, HIT_CODES[S_L]);
        match_s[S_T] = at_probe(ex_s + HALF, ey_s - 12'd1, pixelX, pixelY)
                       && code_in_set(objCode, HIT_CODES[S_T]);
        match_s[S_R] = at_probe(ex_s + SIZE, ey_s + HALF, pixelX, pixelY)
                       && code_in_set(objCode, HIT_CODES[S_R]);
        match_s[S_B] = at_probe(ex_s + HALF, ey_s + SIZE, pixelX, pixelY)
                       && code_in_set(objCode, HIT_CODES[S_B]);
`ifdef HIT_CORNER_PROBES_EN
        // A corner counts only when the code belongs to both adjacent sides,
        // and then it sets both side bits.
        if (at_probe(ex_s - 12'd1, ey_s - 12'd1, pixelX, pixelY)
            && code_in_set(objCode, HIT_CODES[S_L]) && code_in_set(objCode, HIT_CODES[S_T])) begin
            match_s[S_L] = 1'b1;
            match_s[S_T] = 1'b1;
        end else begin
            match_s = match_s;
        end
        if (at_probe(ex_s + SIZE, ey_s - 12'd1, pixelX, pixelY)
            && code_in_set(objCode, HIT_CODES[S_R]) && code_in_set(objCode, HIT_CODES[S_T])) begin
            match_s[S_R] = 1'b1;
            match_s[S_T] = 1'b1;
        end else begin
            match_s = match_s;
        end
        if (at_probe(ex_s - 12'd1, ey_s + SIZE, pixelX, pixelY)
            && code_in_set(objCode, HIT_CODES[S_L]) && code_in_set(objCode, HIT_CODES[S_B])) begin
            match_s[S_L] = 1'b1;
            match_s[S_B] = 1'b1;
        end else begin
            match_s = match_s;
        end
        if (at_probe(ex_s + SIZE, ey_s + SIZE, pixelX, pixelY)
            && code_in_set(objCode, HIT_CODES[S_R]) && code_in_set(objCode, HIT_CODES[S_B])) begin
            match_s[S_R] = 1'b1;
            match_s[S_B] = 1'b1;
        end else begin
            match_s = match_s;
        end
`endif
    end

    // Priority pick of the reported object code from the finished frame.
    always_comb begin
        if (acc_r[S_L]) begin
            prio_obj_s = acc_code_r[S_L];
        end else if (acc_r[S_T]) begin
            prio_obj_s = acc_code_r[S_T];
        end else if (acc_r[S_R]) begin
            prio_obj_s = acc_code_r[S_R];
        end else if (acc_r[S_B]) begin
            prio_obj_s = acc_code_r[S_B];
        end else begin
            prio_obj_s = 4'd0;
        end
    end

    // Next-state, publish and accumulate logic.
    always_comb begin
        state_s     = state_r;
        bx_s        = bx_r;
        by_s        = by_r;
        cd_cnt_s    = cd_cnt_r;
        hit_s       = hit_r;
        hit_obj_s   = hit_obj_r;
        hit_valid_s = 1'b0;
        acc_base_s  = acc_r;
        code_base_s = acc_code_r;

        case (state_r)
            IDLE: begin
                // The first frame edge only arms accumulation; a partial frame
                // is never reported.
                if (startOfFrame) begin
                    state_s     = ACCUM;
                    bx_s        = ballX;
                    by_s        = ballY;
                    acc_base_s  = 4'd0;
                    code_base_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (startOfFrame) begin
                    hit_valid_s = 1'b1;
                    bx_s        = ballX;
                    by_s        = ballY;
                    acc_base_s  = 4'd0;
                    code_base_s = '0;
                    if (cd_cnt_r != 8'd0) begin
                        hit_s     = 4'd0;
                        hit_obj_s = 4'd0;
                        cd_cnt_s  = cd_cnt_r - 8'd1;
                    end else begin
                        hit_s     = acc_r;
                        hit_obj_s = prio_obj_s;
                        if (acc_r != 4'd0) begin
                            cd_cnt_s = CD_LOAD;
                        end else begin
                            cd_cnt_s = cd_cnt_r;
                        end
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Only the first matching code per side is kept.
        if (state_s == ACCUM) begin
            acc_s = acc_base_s | match_s;
            for (int i = 0; i < 4; i++) begin
                if (match_s[i] && !acc_base_s[i]) begin
                    acc_code_s[i] = objCode;
                end else begin
                    acc_code_s[i] = code_base_s[i];
                end
            end
        end else begin
            acc_s      = acc_base_s;
            acc_code_s = code_base_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= IDLE;
            bx_r        <= 11'd0;
            by_r        <= 11'd0;
            acc_r       <= 4'd0;
            acc_code_r  <= '0;
            cd_cnt_r    <= 8'd0;
            hit_r       <= 4'd0;
            hit_obj_r   <= 4'd0;
            hit_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            bx_r        <= bx_s;
            by_r        <= by_s;
            acc_r       <= acc_s;
            acc_code_r  <= acc_code_s;
            cd_cnt_r    <= cd_cnt_s;
            hit_r       <= hit_s;
            hit_obj_r   <= hit_obj_s;
            hit_valid_r <= hit_valid_s;
        end
    end

    assign hit      = hit_r;
    assign hitObj   = hit_obj_r;
    assign hitValid = hit_valid_r;

endmodule
